// File: rtl/floating_point_divider.sv
// Sequential FP32 divider: 26-step restoring mantissa division behind valid/ready handshakes.
// Define FP_DIV_RNE_EN for round-to-nearest-even; otherwise the quotient mantissa is truncated.
module floating_point_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] p,
    output logic [3:0]  flags
);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t             state;
    logic               sign;
    logic signed [9:0]  e_diff;
    logic [23:0]        mb;
    logic [24:0]        rem;
    logic [25:0]        quo;
    logic [4:0]         cnt;

    // Operand classification on the raw inputs, used only at the accept edge.
    logic [7:0] a_exp, b_exp;
    logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic       res_sign;

    assign a_exp    = a[30:23];
    assign b_exp    = b[30:23];
    assign a_zero   = (a_exp == 8'd0);
    assign b_zero   = (b_exp == 8'd0);
    assign a_inf    = (a_exp == 8'hFF) && (a[22:0] == 23'd0);
    assign b_inf    = (b_exp == 8'hFF) && (b[22:0] == 23'd0);
    assign a_nan    = (a_exp == 8'hFF) && (a[22:0] != 23'd0);
    assign b_nan    = (b_exp == 8'hFF) && (b[22:0] != 23'd0);
    assign res_sign = a[31] ^ b[31];

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    logic        is_special;
    logic [31:0] special_p;
    logic [3:0]  special_flags;

    always_comb begin
        is_special    = 1'b1;
        special_p     = 32'd0;
        special_flags = 4'b0000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            special_p     = QNAN;
            special_flags = 4'b1000;
        end else if (a_inf) begin
            special_p = {res_sign, 8'hFF, 23'd0};
        end else if (b_zero) begin
            special_p     = {res_sign, 8'hFF, 23'd0};
            special_flags = 4'b0100;
        end else if (b_inf || a_zero) begin
            special_p = {res_sign, 8'h00, 23'd0};
        end else begin
            is_special = 1'b0;
        end
    end

`ifdef FP_DIV_RNE_EN
    function automatic logic [23:0] round_rne(input logic [22:0] m, input logic g, input logic s);
        return {1'b0, m} + {23'd0, g & (s | m[0])};
    endfunction
`endif

    // Exponent range checks; returns {flags, p}.
    function automatic logic [35:0] saturate_pack(input logic s, input logic signed [9:0] e,
                                                  input logic [22:0] m);
        if (e >= 10'sd255)
            return {4'b0010, s, 8'hFF, 23'd0};
        else if (e <= 10'sd0)
            return {4'b0001, s, 8'h00, 23'd0};
        else
            return {4'b0000, s, e[7:0], m};
    endfunction

    logic [22:0]       mant_t;
    logic signed [9:0] e_t;
    logic [23:0]       mant_r;
    logic signed [9:0] e_r;
    logic [35:0]       packed_res;

    always_comb begin
        if (quo[25]) begin
            mant_t = quo[24:2];
            e_t    = e_diff + 10'sd127;
        end else begin
            mant_t = quo[23:1];
            e_t    = e_diff + 10'sd126;
        end
`ifdef FP_DIV_RNE_EN
        if (quo[25])
            mant_r = round_rne(mant_t, quo[1], quo[0] | (rem != 25'd0));
        else
            mant_r = round_rne(mant_t, quo[0], (rem != 25'd0));
`else
        mant_r = {1'b0, mant_t};
`endif
        e_r        = e_t + $signed({9'd0, mant_r[23]});
        packed_res = saturate_pack(sign, e_r, mant_r[22:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sign   <= 1'b0;
            e_diff <= 10'sd0;
            mb     <= 24'd0;
            rem    <= 25'd0;
            quo    <= 26'd0;
            cnt    <= 5'd0;
            p      <= 32'd0;
            flags  <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        flags <= 4'b0000;
                        sign  <= res_sign;
                        if (is_special) begin
                            p     <= special_p;
                            flags <= special_flags;
                            state <= DONE;
                        end else begin
                            e_diff <= $signed({2'b00, a_exp}) - $signed({2'b00, b_exp});
                            mb     <= {1'b1, b[22:0]};
                            rem    <= {2'b01, a[22:0]};
                            quo    <= 26'd0;
                            cnt    <= 5'd25;
                            state  <= DIV;
                        end
                    end
                end
                DIV: begin
                    // Remainder stays below 2*mb, so the shifted value always fits 25 bits.
                    if (rem >= {1'b0, mb}) begin
                        rem <= (rem - {1'b0, mb}) << 1;
                        quo <= {quo[24:0], 1'b1};
                    end else begin
                        rem <= rem << 1;
                        quo <= {quo[24:0], 1'b0};
                    end
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0)
                        state <= NORM;
                end
                NORM: begin
                    p     <= packed_res[31:0];
                    flags <= packed_res[35:32];
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_floating_point_divider.sv
// Directed bench for floating_point_divider: normal, special, saturation, back-pressure and reset cases.
module tb_floating_point_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] p;
    logic [3:0]  flags;

    int checks = 0;
    int failures = 0;

    floating_point_divider dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .p        (p),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("handoff_out_valid", {31'd0, out_valid}, 32'd0);
        chk("handoff_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                            input logic [31:0] exp_p, input logic [3:0] exp_f, input int exp_lat);
        int lat;
        start_op(av, bv);
        wait_done(lat);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_p"}, p, exp_p);
        chk({tag, "_flags"}, {28'd0, flags}, {28'd0, exp_f});
        consume();
    endtask

    initial begin
        int lat;
        #12;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_p", p, 32'd0);
        chk("reset_flags", {28'd0, flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        check_op("six_div_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 27);
        check_op("neg_six_div_two", 32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 4'b0000, 27);
`ifdef FP_DIV_RNE_EN
        check_op("one_third", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, 27);
`else
        check_op("one_third", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 4'b0000, 27);
`endif
        check_op("neg_one_div_zero", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 4'b0100, 0);
        check_op("zero_div_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 0);
        check_op("inf_div_two", 32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 4'b0000, 0);
        check_op("two_div_neg_inf", 32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, 4'b0000, 0);
        check_op("overflow", 32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 4'b0010, 27);
        check_op("underflow", 32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 4'b0001, 27);

        // Result held under back-pressure while a new operand pair is offered.
        start_op(32'h40C0_0000, 32'h4000_0000);
        wait_done(lat);
        chk("hold_latency", lat, 27);
        @(negedge clk);
        a = 32'h3F80_0000;
        b = 32'h4040_0000;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("hold_p", p, 32'h4040_0000);
            chk("hold_flags", {28'd0, flags}, 32'd0);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        consume();
        @(posedge clk);
        #1;
        chk("idle_after_handoff", {31'd0, in_ready}, 32'd1);

        // Asynchronous reset in the middle of the division loop.
        check_op("pre_reset_op", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 27);
        start_op(32'h3F80_0000, 32'h4040_0000);
        repeat (9) @(posedge clk);
        #2;
        chk("mid_div_busy", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_p", p, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_flags", {28'd0, flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_op("after_reset", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 27);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
